// File: rtl/phy_regfile.sv
// Physical register file: absorbs writeback results, tracks per-entry ready
// bits (cleared by rename, set by writeback/flush), and serves issue-stage
// operand reads with same-cycle write bypass. Entry 0 reads as constant zero.
//
// Handshake: there is no valid/ready flow control here. Every asserted
// wb_phyf_we / rename_phyf_clear bit is accepted on the rising edge it is
// sampled at; upstream never waits.
module phy_regfile #(
  parameter int PHY_REG_NUM    = 64,
  parameter int REG_DATA_WIDTH = 32,
  parameter int WB_WIDTH       = 6,
  parameter int READ_PORT_NUM  = 4,
  parameter int RENAME_WIDTH   = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [WB_WIDTH*$clog2(PHY_REG_NUM)-1:0]      wb_phyf_id,
  input  logic [WB_WIDTH*REG_DATA_WIDTH-1:0]           wb_phyf_data,
  input  logic [WB_WIDTH-1:0]                          wb_phyf_we,
  input  logic [RENAME_WIDTH*$clog2(PHY_REG_NUM)-1:0]  rename_phyf_id,
  input  logic [RENAME_WIDTH-1:0]                      rename_phyf_clear,
  input  logic                                         commit_flush,
  input  logic [READ_PORT_NUM*$clog2(PHY_REG_NUM)-1:0] read_id,
  output logic [READ_PORT_NUM*REG_DATA_WIDTH-1:0]      read_data,
  output logic [READ_PORT_NUM-1:0]                     read_ready,
  output logic                                         dup_write_err
);

  localparam int ID_W = $clog2(PHY_REG_NUM);
  localparam int DW   = REG_DATA_WIDTH;

  logic [DW-1:0]          data_q [PHY_REG_NUM];
  logic [DW-1:0]          data_d [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0] ready_q;
  logic [PHY_REG_NUM-1:0] ready_d;
  logic                   dup_q;
  logic                   dup_d;

  logic [ID_W-1:0] wr_id  [WB_WIDTH];
  logic [DW-1:0]   wr_dat [WB_WIDTH];
  logic [ID_W-1:0] clr_id [RENAME_WIDTH];
  logic [ID_W-1:0] rd_id  [READ_PORT_NUM];

  // Split the flat port buses into per-port fields.
  always_comb begin
    for (int p = 0; p < WB_WIDTH; p++) begin
      wr_id[p]  = wb_phyf_id[p*ID_W +: ID_W];
      wr_dat[p] = wb_phyf_data[p*DW +: DW];
    end
    for (int r = 0; r < RENAME_WIDTH; r++) begin
      clr_id[r] = rename_phyf_id[r*ID_W +: ID_W];
    end
    for (int k = 0; k < READ_PORT_NUM; k++) begin
      rd_id[k] = read_id[k*ID_W +: ID_W];
    end
  end

  // Next array state: writes in ascending port order so the highest port
  // wins, then clears (clear beats write on ready), then flush forces all ready.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    for (int p = 0; p < WB_WIDTH; p++) begin
      if (wb_phyf_we[p] && (wr_id[p] != '0)) begin
        data_d[wr_id[p]]  = wr_dat[p];
        ready_d[wr_id[p]] = 1'b1;
      end
    end
    for (int r = 0; r < RENAME_WIDTH; r++) begin
      if (rename_phyf_clear[r] && (clr_id[r] != '0)) begin
        ready_d[clr_id[r]] = 1'b0;
      end
    end
    if (commit_flush) begin
      ready_d = '1;
    end
  end

  // Sticky error: any two enabled write ports naming the same entry.
  always_comb begin
    dup_d = dup_q;
    for (int a = 0; a < WB_WIDTH; a++) begin
      for (int b = a + 1; b < WB_WIDTH; b++) begin
        if (wb_phyf_we[a] && wb_phyf_we[b] && (wr_id[a] == wr_id[b])) begin
          dup_d = 1'b1;
        end
      end
    end
  end

  // Register array, ready bits and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        data_q[i] <= '0;
      end
      ready_q <= '1;
      dup_q   <= 1'b0;
    end else begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        data_q[i] <= data_d[i];
      end
      ready_q <= ready_d;
      dup_q   <= dup_d;
    end
  end

  // Operand reads: zero entry, then highest-port bypass, then array contents.
  always_comb begin
    read_data  = '0;
    read_ready = '0;
    for (int k = 0; k < READ_PORT_NUM; k++) begin
      if (rd_id[k] == '0) begin
        read_data[k*DW +: DW] = '0;
        read_ready[k]         = 1'b1;
      end else begin
        read_data[k*DW +: DW] = data_q[rd_id[k]];
        read_ready[k]         = ready_q[rd_id[k]];
        for (int p = 0; p < WB_WIDTH; p++) begin
          if (wb_phyf_we[p] && (wr_id[p] == rd_id[k])) begin
            read_data[k*DW +: DW] = wr_dat[p];
            read_ready[k]         = 1'b1;
          end
        end
      end
    end
  end

  assign dup_write_err = dup_q;

endmodule

// File: tb/tb_phy_regfile.sv
// Bench for phy_regfile: directed scenarios plus randomized traffic checked
// against an array-level reference model of the register file.
module tb_phy_regfile;

  localparam int N  = 64;
  localparam int DW = 32;
  localparam int WB = 6;
  localparam int RP = 4;
  localparam int RN = 2;
  localparam int IW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus fields ----------------
  logic [IW-1:0] t_wid  [WB];
  logic [DW-1:0] t_wdat [WB];
  logic [WB-1:0] t_we;
  logic [IW-1:0] t_rnid [RN];
  logic [RN-1:0] t_clr;
  logic          t_flush;
  logic [IW-1:0] t_rid  [RP];

  logic [WB*IW-1:0] wb_phyf_id;
  logic [WB*DW-1:0] wb_phyf_data;
  logic [RN*IW-1:0] rename_phyf_id;
  logic [RP*IW-1:0] read_id;
  logic [RP*DW-1:0] read_data;
  logic [RP-1:0]    read_ready;
  logic             dup_write_err;

  always_comb begin
    for (int p = 0; p < WB; p++) begin
      wb_phyf_id[p*IW +: IW]   = t_wid[p];
      wb_phyf_data[p*DW +: DW] = t_wdat[p];
    end
    for (int r = 0; r < RN; r++) rename_phyf_id[r*IW +: IW] = t_rnid[r];
    for (int k = 0; k < RP; k++) read_id[k*IW +: IW] = t_rid[k];
  end

  phy_regfile dut (
    .clk               (clk),
    .rst               (rst),
    .wb_phyf_id        (wb_phyf_id),
    .wb_phyf_data      (wb_phyf_data),
    .wb_phyf_we        (t_we),
    .rename_phyf_id    (rename_phyf_id),
    .rename_phyf_clear (t_clr),
    .commit_flush      (t_flush),
    .read_id           (read_id),
    .read_data         (read_data),
    .read_ready        (read_ready),
    .dup_write_err     (dup_write_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_data  [N];
  bit            m_ready [N];
  bit            m_dup;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i]  = '0;
      m_ready[i] = 1'b1;
    end
    m_dup = 1'b0;
  endfunction

  // Expected operand for an id given the current stimulus.
  function automatic void model_read(input int id, output logic [DW-1:0] d, output bit rdy);
    d   = m_data[id];
    rdy = m_ready[id];
    if (id == 0) begin
      d   = '0;
      rdy = 1'b1;
    end else begin
      for (int p = WB - 1; p >= 0; p--) begin
        if (t_we[p] && int'(t_wid[p]) == id) begin
          d   = t_wdat[p];
          rdy = 1'b1;
          break;
        end
      end
    end
  endfunction

  // Apply one clock edge's effect of the current stimulus to the model.
  function automatic void model_edge();
    int owner [N];
    bit cleared [N];
    for (int i = 0; i < N; i++) begin
      owner[i]   = -1;
      cleared[i] = 1'b0;
    end
    for (int p = 0; p < WB; p++) begin
      if (t_we[p]) begin
        if (owner[t_wid[p]] >= 0) m_dup = 1'b1;
        owner[t_wid[p]] = p;
      end
    end
    if (!t_flush) begin
      for (int r = 0; r < RN; r++) if (t_clr[r]) cleared[t_rnid[r]] = 1'b1;
    end
    for (int i = 1; i < N; i++) begin
      if (owner[i] >= 0) begin
        m_data[i]  = t_wdat[owner[i]];
        m_ready[i] = 1'b1;
      end
      if (cleared[i]) m_ready[i] = 1'b0;
      if (t_flush) m_ready[i] = 1'b1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rd_data(input int k);
    return read_data[k*DW +: DW];
  endfunction

  task automatic drive_idle();
    for (int p = 0; p < WB; p++) begin
      t_wid[p]  = '0;
      t_wdat[p] = '0;
    end
    t_we    = '0;
    for (int r = 0; r < RN; r++) t_rnid[r] = '0;
    t_clr   = '0;
    t_flush = 1'b0;
    for (int k = 0; k < RP; k++) t_rid[k] = '0;
  endtask

  task automatic check_reads(input string tag);
    logic [DW-1:0] d;
    bit rdy;
    #1;
    for (int k = 0; k < RP; k++) begin
      model_read(int'(t_rid[k]), d, rdy);
      check_val($sformatf("%s_data%0d_id%0d", tag, k, t_rid[k]), 64'(rd_data(k)), 64'(d));
      check_val($sformatf("%s_rdy%0d_id%0d", tag, k, t_rid[k]), 64'(read_ready[k]), 64'(rdy));
    end
  endtask

  // Check reads, take an edge, update the model, check the error flag.
  task automatic step(input string tag);
    check_reads(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_val({tag, "_dup"}, 64'(dup_write_err), 64'(m_dup));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_dup_async", 64'(dup_write_err), 64'd0);
    do_reset();

    // Full sweep of the reset state.
    for (int g = 0; g < N / RP; g++) begin
      for (int k = 0; k < RP; k++) t_rid[k] = IW'(g * RP + k);
      #1;
      for (int k = 0; k < RP; k++) begin
        check_val($sformatf("rst_data_id%0d", g * RP + k), 64'(rd_data(k)), 64'd0);
        check_val($sformatf("rst_rdy_id%0d", g * RP + k), 64'(read_ready[k]), 64'd1);
      end
    end
    check_val("rst_dup", 64'(dup_write_err), 64'd0);

    // Clear 5, then write it through port 2 with bypass.
    drive_idle();
    t_clr[0] = 1'b1; t_rnid[0] = 6'd5;
    step("clr5");
    drive_idle();
    t_rid[0] = 6'd5;
    #1;
    check_val("clr5_rdy", 64'(read_ready[0]), 64'd0);
    t_we[2] = 1'b1; t_wid[2] = 6'd5; t_wdat[2] = 32'hDEADBEEF;
    #1;
    check_val("byp5_data", 64'(rd_data(0)), 64'hDEADBEEF);
    check_val("byp5_rdy", 64'(read_ready[0]), 64'd1);
    step("wr5");
    drive_idle();
    t_rid[0] = 6'd5;
    #1;
    check_val("arr5_data", 64'(rd_data(0)), 64'hDEADBEEF);
    check_val("arr5_rdy", 64'(read_ready[0]), 64'd1);

    // Duplicate write to id 9 from ports 1 and 4.
    t_we[1] = 1'b1; t_wid[1] = 6'd9; t_wdat[1] = 32'h11;
    t_we[4] = 1'b1; t_wid[4] = 6'd9; t_wdat[4] = 32'h44;
    t_rid[1] = 6'd9;
    #1;
    check_val("dup9_byp", 64'(rd_data(1)), 64'h44);
    check_val("dup9_pre", 64'(dup_write_err), 64'd0);
    step("dup9");
    drive_idle();
    t_rid[1] = 6'd9;
    #1;
    check_val("dup9_arr", 64'(rd_data(1)), 64'h44);
    check_val("dup9_flag", 64'(dup_write_err), 64'd1);
    repeat (3) step("dup_hold");
    check_val("dup_sticky", 64'(dup_write_err), 64'd1);

    // Write to entry 0 is dropped.
    drive_idle();
    t_we[0] = 1'b1; t_wid[0] = 6'd0; t_wdat[0] = 32'h1234;
    #1;
    check_val("wr0_byp_data", 64'(rd_data(0)), 64'd0);
    check_val("wr0_byp_rdy", 64'(read_ready[0]), 64'd1);
    step("wr0");
    drive_idle();
    #1;
    check_val("wr0_data", 64'(rd_data(0)), 64'd0);
    check_val("wr0_rdy", 64'(read_ready[0]), 64'd1);

    // Flush overrides same-cycle clear and earlier clears.
    t_clr = 2'b11; t_rnid[0] = 6'd7; t_rnid[1] = 6'd8;
    step("clr78");
    drive_idle();
    t_rid[0] = 6'd7; t_rid[1] = 6'd8;
    #1;
    check_val("clr7_rdy", 64'(read_ready[0]), 64'd0);
    check_val("clr8_rdy", 64'(read_ready[1]), 64'd0);
    t_flush = 1'b1; t_clr[0] = 1'b1; t_rnid[0] = 6'd10;
    step("flush");
    drive_idle();
    t_rid[0] = 6'd7; t_rid[1] = 6'd8; t_rid[2] = 6'd10;
    #1;
    check_val("fl7_rdy", 64'(read_ready[0]), 64'd1);
    check_val("fl8_rdy", 64'(read_ready[1]), 64'd1);
    check_val("fl10_rdy", 64'(read_ready[2]), 64'd1);

    // Write and clear 12 in the same cycle.
    t_we[3] = 1'b1; t_wid[3] = 6'd12; t_wdat[3] = 32'hCAFE0012;
    t_clr[1] = 1'b1; t_rnid[1] = 6'd12;
    t_rid[3] = 6'd12;
    #1;
    check_val("wc12_byp_rdy", 64'(read_ready[3]), 64'd1);
    step("wc12");
    drive_idle();
    t_rid[3] = 6'd12;
    #1;
    check_val("wc12_rdy", 64'(read_ready[3]), 64'd0);
    check_val("wc12_data", 64'(rd_data(3)), 64'hCAFE0012);

    // Reset clears the sticky flag and the array.
    do_reset();
    t_rid[0] = 6'd5; t_rid[1] = 6'd9;
    #1;
    check_val("rst2_dup", 64'(dup_write_err), 64'd0);
    check_val("rst2_d5", 64'(rd_data(0)), 64'd0);
    check_val("rst2_d9", 64'(rd_data(1)), 64'd0);

    // Randomized traffic, duplicates rare so most of the run has a clean flag.
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_idle();
      for (int p = 0; p < WB; p++) begin
        t_we[p]   = ($urandom_range(0, 2) != 0);
        t_wid[p]  = IW'((p * 10 + $urandom_range(0, 9)) % N);
        t_wdat[p] = $urandom;
      end
      if ($urandom_range(0, 19) == 0) t_wid[$urandom_range(1, WB - 1)] = t_wid[0];
      for (int r = 0; r < RN; r++) begin
        t_clr[r]  = ($urandom_range(0, 1) != 0);
        t_rnid[r] = IW'($urandom_range(0, N - 1));
      end
      t_flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < RP; k++) begin
        t_rid[k] = ($urandom_range(0, 1) != 0) ? t_wid[$urandom_range(0, WB - 1)]
                                              : IW'($urandom_range(0, N - 1));
      end
      if (cyc == 200) begin
        // Asynchronous reset landing in the middle of a busy cycle.
        #2;
        rst = 1'b0;
        #1;
        drive_idle();
        model_reset();
        check_reads("midrst");
        check_val("midrst_dup", 64'(dup_write_err), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
      end else begin
        step($sformatf("rnd%0d", cyc));
      end
    end

    // Final sweep of the whole array against the model.
    drive_idle();
    for (int g = 0; g < N / RP; g++) begin
      for (int k = 0; k < RP; k++) t_rid[k] = IW'(g * RP + k);
      check_reads("final");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
